// File: rtl/lns_to_fixed.sv
// lns_to_fixed: sequential decoder from 16-bit LNS words to signed fixed point.
// The fractional part of the logarithm is turned into 2^(f/512) bit-serially
// with a 9-entry ROM. The integer exponent then becomes a barrel shift, and
// negative operands are negated.
// Optional feature: define LNS2FIX_SAT_EN to saturate results whose magnitude
// does not fit in OUT_W bits. Without it, the left shift wraps.
module lns_to_fixed #(
   parameter int OUT_W    = 32,
   parameter int OUT_FRAC = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data
);

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      SCALE,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic             sign_q, sign_d;
   logic [5:0]       exp_q, exp_d;
   logic [8:0]       frac_q, frac_d;
   logic [17:0]      mant_q, mant_d;
   logic [3:0]       idx_q, idx_d;
   logic [OUT_W-1:0] out_q, out_d;

   logic             fracBit;
   logic [35:0]      prod;
   logic signed [7:0] shAmt;
   logic [7:0]       rightAmt;
   logic [OUT_W-1:0] mag;
   logic [OUT_W-1:0] scaled;

   // Q1.17 constants: round(2^(2^(j-9)) * 2^17) for j = 0..8
   function automatic logic [17:0] romLookup(input logic [3:0] j);
      logic [17:0] r;
      case (j)
         4'd0:    r = 18'h200B2;
         4'd1:    r = 18'h20163;
         4'd2:    r = 18'h202C8;
         4'd3:    r = 18'h20593;
         4'd4:    r = 18'h20B36;
         4'd5:    r = 18'h216AB;
         4'd6:    r = 18'h22E57;
         4'd7:    r = 18'h260E0;
         4'd8:    r = 18'h2D414;
         default: r = 18'h20000;
      endcase
      return r;
   endfunction

   // Mantissa step: the current fraction bit selects whether this ROM factor applies
   always_comb begin
      fracBit = |(frac_q & (9'd1 << idx_q));
      prod    = 36'(mant_q) * 36'(romLookup(idx_q));
   end

   // Exponent scaling: move the Q1.17 mantissa to OUT_FRAC fractional bits, then apply the sign
   always_comb begin
      shAmt    = {{2{exp_q[5]}}, exp_q} + 8'(OUT_FRAC - 17);
      rightAmt = 8'(-shAmt);
      if (!shAmt[7]) begin
         mag = OUT_W'(mant_q) << shAmt;
      end else begin
         mag = OUT_W'(mant_q >> rightAmt);
      end
`ifdef LNS2FIX_SAT_EN
      if ($signed(exp_q) >= OUT_W - 1 - OUT_FRAC) begin
         mag = {1'b0, {(OUT_W-1){1'b1}}};
      end
`endif
      scaled = sign_q ? -mag : mag;
   end

   // Next-state logic: accept in IDLE, nine ITER steps, one SCALE step, then hold in DONE
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      frac_d  = frac_q;
      mant_d  = mant_q;
      idx_d   = idx_q;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d = in_data[15];
               exp_d  = in_data[14:9];
               frac_d = in_data[8:0];
               mant_d = 18'h20000;
               idx_d  = 4'd0;
               if (in_data[14:0] == 15'h4000) begin
                  out_d   = '0;
                  state_d = DONE;
               end else begin
                  state_d = ITER;
               end
            end
         end
         ITER: begin
            if (fracBit) begin
               mant_d = 18'(prod >> 17);
            end
            if (idx_q == 4'd8) begin
               state_d = SCALE;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         SCALE: begin
            out_d   = scaled;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any conversion in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         frac_q  <= '0;
         mant_q  <= '0;
         idx_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         frac_q  <= frac_d;
         mant_q  <= mant_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = out_q;

endmodule

// File: tb/tb_lns_to_fixed.sv
// tb_lns_to_fixed: directed bench for lns_to_fixed with a scoreboard queue.
// Define LNS2FIX_SAT_EN here as well as in the RTL when the saturating build is used.
module tb_lns_to_fixed;

   localparam int OUT_W    = 32;
   localparam int OUT_FRAC = 16;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      in_data = 16'h0000;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [OUT_W-1:0] out_data;

   int               testCount = 0;
   int               failCount = 0;
   logic [OUT_W-1:0] expQ[$];
   longint           romModel[9];

   // Free-running clock with a 10 ns period
   always #5 clk = ~clk;

   lns_to_fixed #(.OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
   );

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Exact mantissa iteration: truncated 36-bit products with ROM values derived from reals
   function automatic logic [17:0] modelMant(input logic [8:0] f);
      longint m;
      m = 64'h20000;
      for (int j = 0; j < 9; j++) begin
         if (f[j]) m = (m * romModel[j]) >> 17;
      end
      return m[17:0];
   endfunction

   function automatic logic [OUT_W-1:0] modelOut(input logic [15:0] d);
      int               k;
      int               sh;
      longint           m;
      longint           mag;
      logic [OUT_W-1:0] r;
      if (d[14:0] == 15'h4000) return '0;
      k  = $signed(d[14:9]);
      m  = {46'b0, modelMant(d[8:0])};
      sh = k + OUT_FRAC - 17;
      if (sh >= 0) mag = m << sh;
      else mag = m >> (-sh);
`ifdef LNS2FIX_SAT_EN
      if (k >= OUT_W - 1 - OUT_FRAC) mag = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
`endif
      r = mag[OUT_W-1:0];
      if (d[15]) r = -r;
      return r;
   endfunction

   // Waits for in_ready, presents one operand for a single cycle, then scrambles in_data
   task automatic applyStimulus(input logic [15:0] d, input logic [OUT_W-1:0] exp, input bit push);
      int waitCycles;
      waitCycles = 0;
      @(negedge clk);
      while (!in_ready && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      checkVal("in_ready_before_accept", {63'b0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_data  = d;
      if (push) expQ.push_back(exp);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
   endtask

   // Measures latency, pops the scoreboard, optionally applies backpressure, then handshakes
   task automatic checkOutput(input string tag, input int expLat, input int holdCycles,
                              output logic [OUT_W-1:0] seen);
      int               cycles;
      logic [OUT_W-1:0] exp;
      bit               stable;
      cycles = 1;
      stable = 1'b1;
      while (!out_valid && cycles < 60) begin
         @(negedge clk);
         cycles++;
      end
      checkVal({tag, "_latency"}, 64'(cycles), 64'(expLat));
      if (expQ.size() > 0) exp = expQ.pop_front();
      else exp = 'x;
      seen = out_data;
      checkVal({tag, "_data"}, 64'(out_data), 64'(exp));
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge clk);
         if (out_data !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
      end
      if (holdCycles > 0) checkVal({tag, "_hold_stable"}, {63'b0, stable}, 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkVal({tag, "_ready_after"}, {62'b0, in_ready, out_valid}, 64'd2);
   endtask

   // Time-limit guard so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [OUT_W-1:0] seen;
      longint           ideal;
      longint           err;
      longint           maxErr;
      bit               quiet;

      for (int j = 0; j < 9; j++) begin
         romModel[j] = longint'($rtoi($pow(2.0, $pow(2.0, real'(j) - 9.0)) * 131072.0 + 0.5));
      end

      // Reset values
      repeat (2) @(negedge clk);
      checkVal("reset_outputs", {31'b0, in_ready, out_valid, out_data}, {31'b0, 1'b1, 1'b0, 32'h0});
      reset_n = 1'b1;

      // Directed values with hand-derived results
      applyStimulus(16'h0000, 32'h0001_0000, 1'b1);
      checkOutput("plus_one", 11, 0, seen);
      applyStimulus(16'h0200, 32'h0002_0000, 1'b1);
      checkOutput("plus_two", 11, 0, seen);
      applyStimulus(16'h7E00, 32'h0000_8000, 1'b1);
      checkOutput("plus_half", 11, 0, seen);
      applyStimulus(16'h8200, 32'hFFFE_0000, 1'b1);
      checkOutput("minus_two", 11, 0, seen);
      applyStimulus(16'h0100, 32'h0001_6A0A, 1'b1);
      checkOutput("sqrt_two", 11, 0, seen);

      // Zero encodings, sign ignored
      applyStimulus(16'h4000, 32'h0, 1'b1);
      checkOutput("zero_pos", 1, 0, seen);
      applyStimulus(16'hC000, 32'h0, 1'b1);
      checkOutput("zero_neg", 1, 0, seen);

      // Largest exponent: saturates or wraps depending on the build
`ifdef LNS2FIX_SAT_EN
      applyStimulus(16'h3FFF, 32'h7FFF_FFFF, 1'b1);
      checkOutput("max_pos", 11, 0, seen);
      applyStimulus(16'hBFFF, 32'h8000_0001, 1'b1);
      checkOutput("max_neg", 11, 0, seen);
`else
      applyStimulus(16'h3FFF, modelOut(16'h3FFF), 1'b1);
      checkOutput("max_pos", 11, 0, seen);
      applyStimulus(16'hBFFF, modelOut(16'hBFFF), 1'b1);
      checkOutput("max_neg", 11, 0, seen);
`endif

      // Deep underflow: every mantissa bit shifts out, negative stays zero
      applyStimulus(16'hC1FF, 32'h0, 1'b1);
      checkOutput("underflow_neg", 11, 0, seen);

      // Backpressure for 20 cycles, then a second operand
      applyStimulus(16'h0200, 32'h0002_0000, 1'b1);
      checkOutput("backpressure", 11, 20, seen);
      applyStimulus(16'h7E00, 32'h0000_8000, 1'b1);
      checkOutput("after_backpressure", 11, 0, seen);

      // Sweep every fraction at k = 0: exact model plus a sanity bound against the real value.
      // Nine truncated products and the final right shift all round down, so the
      // deviation from the ideal value can reach a few output LSBs.
      maxErr = 0;
      for (int f = 0; f < 512; f++) begin
         logic [15:0] d;
         d = {7'b0, 9'(f)};
         applyStimulus(d, modelOut(d), 1'b1);
         checkOutput("sweep", 11, 0, seen);
         ideal = longint'($rtoi($pow(2.0, real'(f) / 512.0) * 65536.0 + 0.5));
         err   = ideal - longint'(seen);
         if (err < 0) err = -err;
         if (err > maxErr) maxErr = err;
      end
      checkVal("sweep_real_bound", {63'b0, (maxErr <= 6)}, 64'd1);

      // Reset during ITER at j = 4 aborts the conversion
      applyStimulus(16'h0200, 32'h0, 1'b0);
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkVal("reset_abort", {31'b0, in_ready, out_valid, out_data}, {31'b0, 1'b1, 1'b0, 32'h0});
      @(negedge clk);
      reset_n = 1'b1;
      quiet = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (out_valid !== 1'b0) quiet = 1'b0;
      end
      checkVal("abort_no_output", {63'b0, quiet}, 64'd1);
      applyStimulus(16'h0000, 32'h0001_0000, 1'b1);
      checkOutput("after_reset", 11, 0, seen);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
